// File: rtl/reg_file_wb.sv
// reg_file_wb: write-back register file with 8 GPRs, a private SP with push/pop,
// and two combinational read ports with write-through bypass.
module reg_file_wb #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 4,
    parameter int                 NUM_REGS = 8,
    parameter logic [DATA_W-1:0]  SP_RESET = 16'h07FF,
    parameter int                 SP_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic              wb_private,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [1:0]        sp_op,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] sp_next
);
    localparam int                IW   = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0]   NR   = NUM_REGS[ADDR_W:0];
    localparam logic [DATA_W-1:0] STEP = DATA_W'(SP_STEP);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] sp_q, sp_d;
    logic              gpr_we;

    assign gpr_we = wb_en && !wb_private && ({1'b0, wb_addr} < NR);

    // Reads are forced to zero while reset is asserted so no pre-reset state or bypass leaks out.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        if (rst)
            return '0;
        if (gpr_we && a == wb_addr)
            return wb_data;
        return ({1'b0, a} < NR) ? regs_q[a[IW-1:0]] : '0;
    endfunction

    assign rd_data_a = rd(rd_addr_a);
    assign rd_data_b = rd(rd_addr_b);
    assign sp        = sp_q;
    assign sp_next   = (sp_op == 2'b10) ? sp_q + STEP : sp_q;

    always_comb begin
        regs_d = regs_q;
        if (gpr_we)
            regs_d[wb_addr[IW-1:0]] = wb_data;
        sp_d = (wb_en && wb_private) ? wb_data :
               (sp_op == 2'b01)      ? sp_q - STEP :
               (sp_op == 2'b10)      ? sp_q + STEP : sp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            sp_q <= SP_RESET;
        end else begin
            regs_q <= regs_d;
            sp_q   <= sp_d;
        end
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed scenarios plus randomized traffic against an array-based model.
module tb_reg_file_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en = 1'b0, wb_private = 1'b0;
    logic [3:0]  wb_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [15:0] wb_data = '0;
    logic [1:0]  sp_op = '0;
    logic [15:0] rd_data_a, rd_data_b, sp, sp_next;

    logic [15:0] m_reg [8];
    logic [15:0] m_sp = 16'h07FF;
    int errors = 0, checks = 0;

    reg_file_wb dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_private(wb_private),
        .wb_addr(wb_addr), .wb_data(wb_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .sp_op(sp_op), .sp(sp), .sp_next(sp_next)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_rd(input logic [3:0] a);
        if (rst)
            return 16'h0;
        if (wb_en && !wb_private && wb_addr < 4'd8 && a == wb_addr)
            return wb_data;
        return (a < 4'd8) ? m_reg[a[2:0]] : 16'h0;
    endfunction

    task automatic tick();
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 16'h0;
            m_sp = 16'h07FF;
        end else begin
            if (wb_en && !wb_private && wb_addr < 4'd8)
                m_reg[wb_addr[2:0]] = wb_data;
            if (wb_en && wb_private)
                m_sp = wb_data;
            else if (sp_op == 2'b01)
                m_sp = m_sp - 16'd1;
            else if (sp_op == 2'b10)
                m_sp = m_sp + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; wb_en = 1; wb_private = 0; wb_addr = 4'd3; wb_data = 16'hBEEF; sp_op = 2'b01;
        tick();
        tick();
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a);
            #1;
            checks += 2;
            if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset_rd_a addr=%0d got=%h exp=0000", a, rd_data_a); end
            if (rd_data_b !== 16'h0) begin errors++; $display("FAIL reset_rd_b addr=%0d got=%h exp=0000", 15 - a, rd_data_b); end
        end
        checks++;
        if (sp !== 16'h07FF) begin errors++; $display("FAIL reset_sp got=%h exp=07ff", sp); end
        rst = 0; wb_en = 0; sp_op = 2'b00; rd_addr_a = 4'd3;
        tick();
        checks += 2;
        if (sp !== 16'h07FF) begin errors++; $display("FAIL reset_sp_after got=%h exp=07ff", sp); end
        if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset_r3_after got=%h exp=0000", rd_data_a); end
    endtask

    task automatic test_gpr();
        wb_en = 1; wb_private = 0; wb_addr = 4'd3; wb_data = 16'h1234; rd_addr_a = 4'd3; rd_addr_b = 4'd5;
        #1;
        checks += 2;
        if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL gpr_bypass got=%h exp=1234", rd_data_a); end
        if (rd_data_b !== 16'h0) begin errors++; $display("FAIL gpr_r5_before got=%h exp=0000", rd_data_b); end
        tick();
        wb_en = 0;
        #1;
        checks += 2;
        if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL gpr_stored got=%h exp=1234", rd_data_a); end
        if (rd_data_b !== 16'h0) begin errors++; $display("FAIL gpr_r5_after got=%h exp=0000", rd_data_b); end
    endtask

    task automatic test_unimpl();
        wb_en = 1; wb_private = 0; wb_addr = 4'hA; wb_data = 16'hFFFF; rd_addr_a = 4'hA;
        #1;
        checks++;
        if (rd_data_a !== 16'h0) begin errors++; $display("FAIL unimpl_bypass got=%h exp=0000", rd_data_a); end
        tick();
        wb_en = 0;
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            #1;
            checks++;
            if (rd_data_a !== m_rd(rd_addr_a)) begin errors++; $display("FAIL unimpl_scan addr=%0d got=%h exp=%h", a, rd_data_a, m_rd(rd_addr_a)); end
        end
        rd_addr_a = 4'd3;
        #1;
        checks++;
        if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL unimpl_r3_kept got=%h exp=1234", rd_data_a); end
    endtask

    task automatic test_sp_wrap();
        wb_en = 1; wb_private = 1; wb_data = 16'h0001; wb_addr = 4'd2;
        tick();
        wb_en = 0; wb_private = 0;
        checks++;
        if (sp !== 16'h0001) begin errors++; $display("FAIL sp_write got=%h exp=0001", sp); end
        sp_op = 2'b01;
        tick();
        checks++;
        if (sp !== 16'h0000) begin errors++; $display("FAIL sp_push1 got=%h exp=0000", sp); end
        tick();
        checks++;
        if (sp !== 16'hFFFF) begin errors++; $display("FAIL sp_push_wrap got=%h exp=ffff", sp); end
        sp_op = 2'b10;
        #1;
        checks++;
        if (sp_next !== 16'h0000) begin errors++; $display("FAIL sp_next_pop got=%h exp=0000", sp_next); end
        tick();
        sp_op = 2'b00;
        #1;
        checks += 2;
        if (sp !== 16'h0000) begin errors++; $display("FAIL sp_pop_wrap got=%h exp=0000", sp); end
        if (sp_next !== 16'h0000) begin errors++; $display("FAIL sp_next_idle got=%h exp=0000", sp_next); end
    endtask

    task automatic test_collision();
        wb_en = 1; wb_private = 1; wb_data = 16'h0100;
        tick();
        wb_data = 16'h0200; sp_op = 2'b10;
        tick();
        wb_en = 0; wb_private = 0; sp_op = 2'b00;
        checks++;
        if (sp !== 16'h0200) begin errors++; $display("FAIL collision_sp got=%h exp=0200", sp); end
    endtask

    task automatic test_dual_bypass_reset();
        rd_addr_a = 4'd7; rd_addr_b = 4'd7;
        wb_en = 1; wb_private = 0; wb_addr = 4'd7; wb_data = 16'hA5A5; sp_op = 2'b01;
        #1;
        checks += 2;
        if (rd_data_a !== 16'hA5A5) begin errors++; $display("FAIL dual_bypass_a got=%h exp=a5a5", rd_data_a); end
        if (rd_data_b !== 16'hA5A5) begin errors++; $display("FAIL dual_bypass_b got=%h exp=a5a5", rd_data_b); end
        tick();
        wb_en = 0; rst = 1; sp_op = 2'b01;
        tick();
        rst = 0; sp_op = 2'b00;
        #1;
        checks += 3;
        if (rd_data_a !== 16'h0) begin errors++; $display("FAIL midop_reset_a got=%h exp=0000", rd_data_a); end
        if (rd_data_b !== 16'h0) begin errors++; $display("FAIL midop_reset_b got=%h exp=0000", rd_data_b); end
        if (sp !== 16'h07FF) begin errors++; $display("FAIL midop_reset_sp got=%h exp=07ff", sp); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            wb_en      = 1'($urandom);
            wb_private = ($urandom_range(0, 3) == 0);
            wb_addr    = 4'($urandom);
            wb_data    = 16'($urandom);
            sp_op      = 2'($urandom);
            rd_addr_a  = ($urandom_range(0, 2) == 0) ? wb_addr : 4'($urandom);
            rd_addr_b  = ($urandom_range(0, 2) == 0) ? wb_addr : 4'($urandom);
            #1;
            checks += 3;
            if (rd_data_a !== m_rd(rd_addr_a)) begin errors++; $display("FAIL rand_rd_a n=%0d addr=%h got=%h exp=%h", n, rd_addr_a, rd_data_a, m_rd(rd_addr_a)); end
            if (rd_data_b !== m_rd(rd_addr_b)) begin errors++; $display("FAIL rand_rd_b n=%0d addr=%h got=%h exp=%h", n, rd_addr_b, rd_data_b, m_rd(rd_addr_b)); end
            if (sp_next !== ((sp_op == 2'b10) ? m_sp + 16'd1 : m_sp)) begin errors++; $display("FAIL rand_sp_next n=%0d got=%h exp=%h", n, sp_next, (sp_op == 2'b10) ? m_sp + 16'd1 : m_sp); end
            tick();
            checks++;
            if (sp !== m_sp) begin errors++; $display("FAIL rand_sp n=%0d got=%h exp=%h", n, sp, m_sp); end
        end
        rst = 0; wb_en = 0; sp_op = 2'b00;
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 16'h0;
        test_reset();
        test_gpr();
        test_unimpl();
        test_sp_wrap();
        test_collision();
        test_dual_bypass_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
